// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM state and memory-arbiter FSM encodings,
// plus the saturating counter helper used by the arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : (v + 4'd1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU requester and RAM signals around the memory arbiter.
// master = arbiter view, slave = CPU/RAM environment view.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      datomic;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, datomic, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, datomic, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_llsc_link.sv
// LL/SC link register: set by a completed LL, cleared by any completed SC
// or by a completed plain store to the linked address. Built only with LLSC_EN.
`ifdef LLSC_EN
module llsc_link
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ll_done,
  input  logic  sc_done,
  input  logic  st_done,
  input  word_t daddr,
  output logic  sc_ok
);

  logic  link_valid_r;
  word_t link_addr_r;

  // Link valid/address tracking
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_r <= 1'b0;
      link_addr_r  <= 32'h0000_0000;
    end else if (ll_done) begin
      link_valid_r <= 1'b1;
      link_addr_r  <= daddr;
    end else if (sc_done || (st_done && (daddr == link_addr_r))) begin
      link_valid_r <= 1'b0;
    end else begin
      link_valid_r <= link_valid_r;
    end
  end

  assign sc_ok = link_valid_r && (daddr == link_addr_r);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data
// first with a bounded run against pending fetch. LLSC_EN adds the LL/SC link.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DATA_RUN = 1
) (
  input  logic CLK,
  input  logic nRST,
  mem_arbiter_if.master bus
);

  localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

  arb_state_t state_r;
  arb_state_t state_next_s;
  logic [3:0] run_cnt_r;
  logic       dreq_s;
  logic       sc_s;
  logic       sc_ok_s;
  logic       sc_fail_s;
  logic       ram_access_s;
  logic       ram_err_s;
  logic       icomp_s;
  logic       dcomp_s;

  assign dreq_s       = bus.dREN | bus.dWEN;
  assign ram_access_s = (bus.ramstate == ACCESS);
  assign ram_err_s    = (bus.ramstate == ERROR);

`ifdef LLSC_EN
  assign sc_s = bus.dWEN & bus.datomic;

  llsc_link u_link (
    .CLK     (CLK),
    .nRST    (nRST),
    .ll_done (dcomp_s & bus.dREN & bus.datomic),
    .sc_done (dcomp_s & sc_s),
    .st_done (dcomp_s & bus.dWEN & ~bus.datomic),
    .daddr   (bus.daddr),
    .sc_ok   (sc_ok_s)
  );
`else
  logic unused_datomic_s;
  assign unused_datomic_s = bus.datomic;
  assign sc_s             = 1'b0;
  assign sc_ok_s          = 1'b0;
`endif

  // A failing SC never touches RAM and finishes in its first grant cycle.
  assign sc_fail_s = sc_s & ~sc_ok_s;
  assign icomp_s   = (state_r == IGRANT) & bus.iREN & ram_access_s;
  assign dcomp_s   = (state_r == DGRANT) & dreq_s & (sc_fail_s | ram_access_s);

  // Grant state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Consecutive data completions while fetch is kept waiting
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      run_cnt_r <= 4'd0;
    end else if (!bus.iREN || icomp_s) begin
      run_cnt_r <= 4'd0;
    end else if (dcomp_s) begin
      run_cnt_r <= sat_inc(run_cnt_r, MAX_RUN);
    end else begin
      run_cnt_r <= run_cnt_r;
    end
  end

  // Arbitration and grant exit
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (dreq_s && (!bus.iREN || (run_cnt_r < MAX_RUN))) begin
          state_next_s = DGRANT;
        end else if (bus.iREN) begin
          state_next_s = IGRANT;
        end else begin
          state_next_s = IDLE;
        end
      end
      DGRANT: begin
        if (!dreq_s || dcomp_s || ram_err_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DGRANT;
        end
      end
      IGRANT: begin
        if (!bus.iREN || ram_access_s || ram_err_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = IGRANT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // RAM steering from the granted requester
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0000_0000;
    bus.ramstore = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        bus.ramREN = 1'b0;
      end
      DGRANT: begin
        bus.ramREN   = bus.dREN & ~ram_err_s;
        bus.ramWEN   = bus.dWEN & ~sc_fail_s & ~ram_err_s;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      IGRANT: begin
        bus.ramREN  = bus.iREN & ~ram_err_s;
        bus.ramaddr = bus.iaddr;
      end
      default: begin
        bus.ramREN = 1'b0;
      end
    endcase
  end

  assign bus.iwait = bus.iREN & ~icomp_s;
  assign bus.dwait = dreq_s & ~dcomp_s;
  assign bus.iload = icomp_s ? bus.ramload : 32'h0000_0000;
  assign bus.dload = !dcomp_s ? 32'h0000_0000 :
                     sc_s     ? {31'h0000_0000, sc_ok_s} : bus.ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MAX_DATA_RUN 1 and 2).
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if ia ();
  mem_arbiter_if ib ();

  mem_arbiter #(.MAX_DATA_RUN(1)) dut_a (.CLK(CLK), .nRST(nRST), .bus(ia));
  mem_arbiter #(.MAX_DATA_RUN(2)) dut_b (.CLK(CLK), .nRST(nRST), .bus(ib));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic clear_a;
    ia.iREN = 1'b0; ia.iaddr = 32'h0; ia.dREN = 1'b0; ia.dWEN = 1'b0;
    ia.daddr = 32'h0; ia.dstore = 32'h0; ia.datomic = 1'b0;
    ia.ramload = 32'h0; ia.ramstate = FREE;
  endtask

  task automatic clear_b;
    ib.iREN = 1'b0; ib.iaddr = 32'h0; ib.dREN = 1'b0; ib.dWEN = 1'b0;
    ib.daddr = 32'h0; ib.dstore = 32'h0; ib.datomic = 1'b0;
    ib.ramload = 32'h0; ib.ramstate = FREE;
  endtask

  logic [31:0] order_exp [6];

  initial begin
    order_exp[0] = 32'h100; order_exp[1] = 32'h100; order_exp[2] = 32'h40;
    order_exp[3] = 32'h100; order_exp[4] = 32'h100; order_exp[5] = 32'h40;
    nRST = 1'b0;
    clear_a();
    clear_b();
    tick(); tick();
    settle();
    chk("rst_ramREN", ia.ramREN, 1'b0);
    chk("rst_ramWEN", ia.ramWEN, 1'b0);
    chk("rst_ramaddr", ia.ramaddr, 32'h0);
    chk("rst_ramstore", ia.ramstore, 32'h0);
    chk("rst_iload", ia.iload, 32'h0);
    chk("rst_dload", ia.dload, 32'h0);
    chk("rst_iwait", ia.iwait, 1'b0);
    chk("rst_dwait", ia.dwait, 1'b0);
    tick();
    nRST = 1'b1;

    // lone instruction fetch, ACCESS on first grant cycle
    tick();
    ia.iREN = 1'b1; ia.iaddr = 32'h40; ia.ramstate = ACCESS; ia.ramload = 32'h8C22_0004;
    settle();
    chk("if_req_iwait", ia.iwait, 1'b1);
    chk("if_req_ramREN", ia.ramREN, 1'b0);
    tick(); settle();
    chk("if_grant_ramREN", ia.ramREN, 1'b1);
    chk("if_grant_ramaddr", ia.ramaddr, 32'h40);
    chk("if_done_iwait", ia.iwait, 1'b0);
    chk("if_done_iload", ia.iload, 32'h8C22_0004);
    tick();
    ia.iREN = 1'b0;
    settle();
    chk("if_after_ramREN", ia.ramREN, 1'b0);

    // simultaneous requests with MAX_DATA_RUN=1: D, I, then D again
    tick();
    ia.iREN = 1'b1; ia.iaddr = 32'h40; ia.dREN = 1'b1; ia.daddr = 32'h100;
    ia.ramstate = ACCESS; ia.ramload = 32'h1111_1111;
    settle();
    chk("sim_idle_iwait", ia.iwait, 1'b1);
    chk("sim_idle_dwait", ia.dwait, 1'b1);
    tick(); settle();
    chk("sim_d_ramaddr", ia.ramaddr, 32'h100);
    chk("sim_d_dwait", ia.dwait, 1'b0);
    chk("sim_d_iwait", ia.iwait, 1'b1);
    chk("sim_d_dload", ia.dload, 32'h1111_1111);
    tick(); settle();
    chk("sim_idle2_ramREN", ia.ramREN, 1'b0);
    tick(); settle();
    chk("sim_i_ramaddr", ia.ramaddr, 32'h40);
    chk("sim_i_iwait", ia.iwait, 1'b0);
    chk("sim_i_dwait", ia.dwait, 1'b1);
    tick(); tick(); settle();
    chk("sim_d2_ramaddr", ia.ramaddr, 32'h100);
    chk("sim_d2_dwait", ia.dwait, 1'b0);
    tick();
    clear_a();

    // continuous requests with MAX_DATA_RUN=2: D, D, I, D, D, I
    ib.iREN = 1'b1; ib.iaddr = 32'h40; ib.dREN = 1'b1; ib.daddr = 32'h100;
    ib.ramstate = ACCESS; ib.ramload = 32'h2222_2222;
    for (int k = 0; k < 6; k++) begin
      tick(); settle();
      chk($sformatf("order_%0d", k), ib.ramaddr, order_exp[k]);
      tick();
    end
    clear_b();

    // write held BUSY for three cycles, ACCESS on the fourth grant cycle
    tick();
    ia.dWEN = 1'b1; ia.daddr = 32'h200; ia.dstore = 32'hDEAD_BEEF; ia.ramstate = BUSY;
    settle();
    chk("busy_req_ramWEN", ia.ramWEN, 1'b0);
    chk("busy_req_dwait", ia.dwait, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      chk($sformatf("busy_%0d_ramWEN", k), ia.ramWEN, 1'b1);
      chk($sformatf("busy_%0d_dwait", k), ia.dwait, 1'b1);
    end
    tick();
    ia.ramstate = ACCESS;
    settle();
    chk("busy_done_ramWEN", ia.ramWEN, 1'b1);
    chk("busy_done_ramstore", ia.ramstore, 32'hDEAD_BEEF);
    chk("busy_done_dwait", ia.dwait, 1'b0);
    tick();
    ia.dWEN = 1'b0;
    settle();
    chk("busy_after_ramWEN", ia.ramWEN, 1'b0);

    // fetch withdrawn mid-grant
    tick();
    ia.iREN = 1'b1; ia.iaddr = 32'h44; ia.ramstate = BUSY;
    tick(); settle();
    chk("wd_grant_ramREN", ia.ramREN, 1'b1);
    tick();
    ia.iREN = 1'b0;
    settle();
    chk("wd_ramREN", ia.ramREN, 1'b0);
    chk("wd_iwait", ia.iwait, 1'b0);
    tick();
    ia.iREN = 1'b1; ia.ramstate = ACCESS;
    settle();
    chk("wd_back_idle", ia.ramREN, 1'b0);
    tick(); settle();
    chk("wd_regrant_iwait", ia.iwait, 1'b0);
    tick();
    ia.iREN = 1'b0;

    // RAM ERROR: stay waiting and get re-arbitrated
    tick();
    ia.iREN = 1'b1; ia.iaddr = 32'h48; ia.ramstate = ERROR;
    tick(); settle();
    chk("err_iwait", ia.iwait, 1'b1);
    tick();
    ia.ramstate = ACCESS; ia.ramload = 32'h3333_3333;
    settle();
    chk("err_idle_ramREN", ia.ramREN, 1'b0);
    chk("err_idle_iwait", ia.iwait, 1'b1);
    tick(); settle();
    chk("err_retry_iwait", ia.iwait, 1'b0);
    chk("err_retry_ramaddr", ia.ramaddr, 32'h48);
    tick();
    ia.iREN = 1'b0;

    // reset asserted during a BUSY instruction grant
    tick();
    ia.iREN = 1'b1; ia.iaddr = 32'h4C; ia.ramstate = BUSY;
    tick(); settle();
    chk("rg_grant_ramREN", ia.ramREN, 1'b1);
    tick();
    nRST = 1'b0;
    settle();
    chk("rg_rst_ramREN", ia.ramREN, 1'b0);
    chk("rg_rst_iwait", ia.iwait, 1'b1);
    tick();
    nRST = 1'b1; ia.ramstate = ACCESS; ia.ramload = 32'h4444_4444;
    settle();
    chk("rg_idle_ramREN", ia.ramREN, 1'b0);
    tick(); settle();
    chk("rg_regrant_ramREN", ia.ramREN, 1'b1);
    chk("rg_regrant_iwait", ia.iwait, 1'b0);
    chk("rg_regrant_iload", ia.iload, 32'h4444_4444);
    tick();
    ia.iREN = 1'b0;

`ifdef LLSC_EN
    // LL, plain SW to the link, SC must fail
    tick();
    ia.dREN = 1'b1; ia.datomic = 1'b1; ia.daddr = 32'h300;
    ia.ramstate = ACCESS; ia.ramload = 32'h5555_5555;
    tick(); settle();
    chk("ll1_dwait", ia.dwait, 1'b0);
    tick();
    ia.dREN = 1'b0; ia.datomic = 1'b0; ia.dWEN = 1'b1; ia.dstore = 32'h77;
    tick(); settle();
    chk("sw_ramWEN", ia.ramWEN, 1'b1);
    tick();
    ia.datomic = 1'b1; ia.ramstate = BUSY;
    tick(); settle();
    chk("scf_ramWEN", ia.ramWEN, 1'b0);
    chk("scf_dwait", ia.dwait, 1'b0);
    chk("scf_dload", ia.dload, 32'h0);
    tick();
    ia.dWEN = 1'b0; ia.dREN = 1'b1; ia.ramstate = ACCESS;
    tick(); settle();
    chk("ll2_dwait", ia.dwait, 1'b0);
    tick();
    ia.dREN = 1'b0; ia.dWEN = 1'b1; ia.dstore = 32'h99;
    tick(); settle();
    chk("scs_ramWEN", ia.ramWEN, 1'b1);
    chk("scs_dwait", ia.dwait, 1'b0);
    chk("scs_dload", ia.dload, 32'h1);
    tick();
    clear_a();
`else
    // atomics behave as plain LW/SW
    tick();
    ia.dWEN = 1'b1; ia.datomic = 1'b1; ia.daddr = 32'h300; ia.dstore = 32'h99;
    ia.ramstate = ACCESS; ia.ramload = 32'h1234;
    tick(); settle();
    chk("sc_plain_ramWEN", ia.ramWEN, 1'b1);
    chk("sc_plain_dload", ia.dload, 32'h1234);
    tick();
    ia.dWEN = 1'b0; ia.dREN = 1'b1; ia.ramload = 32'h5678;
    tick(); settle();
    chk("ll_plain_ramREN", ia.ramREN, 1'b1);
    chk("ll_plain_dload", ia.dload, 32'h5678);
    tick();
    clear_a();
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
